// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with a valid/ready handshake, a 2-entry skid buffer and a synchronous flush.
// Optional macro PIPE_STAGE_PERF_EN adds the stall_count and bubble_count performance counters.
module pipe_stage_reg #(
  parameter int unsigned WIDTH          = 64,
  parameter bit          CLEAR_ON_FLUSH = 1'b1,
  parameter int unsigned CNT_W          = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] bubble_count
`endif
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] main_q;
  logic [WIDTH-1:0] skid_q;
  logic             out_valid_q;
  logic             in_ready_q;
  logic             in_fire;
  logic             out_fire;

  assign in_fire   = in_valid & in_ready_q;
  assign out_fire  = out_valid_q & out_ready;
  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = main_q;

  // in_ready and out_valid are registered alongside the state so neither depends on out_ready.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= EMPTY;
      main_q      <= '0;
      skid_q      <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else if (flush) begin
      state_q     <= EMPTY;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      if (CLEAR_ON_FLUSH) begin
        main_q <= '0;
        skid_q <= '0;
      end
    end else begin
      case (state_q)
        EMPTY: begin
          if (in_fire) begin
            state_q     <= ONE;
            main_q      <= in_data;
            out_valid_q <= 1'b1;
            in_ready_q  <= 1'b1;
          end
        end
        ONE: begin
          if (in_fire && !out_fire) begin
            state_q    <= FULL;
            skid_q     <= in_data;
            in_ready_q <= 1'b0;
          end else if (!in_fire && out_fire) begin
            state_q     <= EMPTY;
            out_valid_q <= 1'b0;
          end else if (in_fire && out_fire) begin
            main_q <= in_data;
          end
        end
        FULL: begin
          if (out_fire) begin
            state_q    <= ONE;
            main_q     <= skid_q;
            in_ready_q <= 1'b1;
          end
        end
        default: begin
          state_q     <= EMPTY;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
        end
      endcase
    end
  end

`ifdef PIPE_STAGE_PERF_EN
  logic [CNT_W-1:0] stall_q;
  logic [CNT_W-1:0] bubble_q;

  // Counters are deliberately untouched by flush; they wrap naturally.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_q  <= '0;
      bubble_q <= '0;
    end else begin
      if (out_valid_q && !out_ready) stall_q <= stall_q + 1'b1;
      if (!out_valid_q && out_ready) bubble_q <= bubble_q + 1'b1;
    end
  end

  assign stall_count  = stall_q;
  assign bubble_count = bubble_q;
`endif

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised pipeline stage register; next generation of the fixed IF/ID latch.
- Carries an opaque WIDTH-bit payload (instr, pc, decoded fields packed by the caller) between any two pipeline stages.
- Uses valid/ready handshake, synchronous flush, and a 2-entry skid buffer, so in_ready is registered and has no combinational path from out_ready.

Parameters:
- WIDTH, 64, payload width in bits (e.g. {pc, instr}); must be >= 1.
- CLEAR_ON_FLUSH, 1, when 1 a flush zeroes the payload registers; when 0 they hold their stale value.
- CNT_W, 32, width of performance counters (optional feature only).

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset (asserted when 0).
- flush  in  1  synchronous squash of all held entries.
- in_valid  in  1  upstream payload valid.
- in_ready  out  1  stage can accept; driven directly from a state flop.
- in_data  in  WIDTH  upstream payload.
- out_valid  out  1  downstream payload valid.
- out_ready  in  1  downstream accepts.
- out_data  out  WIDTH  payload to downstream; driven from the main register.
- stall_count  out  CNT_W  present only with PIPE_STAGE_PERF_EN.
- bubble_count  out  CNT_W  present only with PIPE_STAGE_PERF_EN.

Behaviour:
- Handshake events:
  - in_fire = in_valid & in_ready.
  - out_fire = out_valid & out_ready.
- Storage: main register (drives out_data) and skid register.
- States:
  - EMPTY: out_valid=0, in_ready=1.
  - ONE: out_valid=1, in_ready=1.
  - FULL: out_valid=1, in_ready=0.
- Reset (rst=0, async): state=EMPTY, main=0, skid=0. Hence out_valid=0, in_ready=1, out_data=0. Counters reset to 0.
- Transitions when flush=0:
  - EMPTY, in_fire: -> ONE, main<=in_data.
  - ONE, in_fire & !out_fire: -> FULL, skid<=in_data, main unchanged.
  - ONE, !in_fire & out_fire: -> EMPTY.
  - ONE, in_fire & out_fire: stay ONE, main<=in_data.
  - FULL, out_fire: -> ONE, main<=skid. in_fire is impossible in FULL.
  - Any state with no fire: hold everything.
- Flush: highest priority over all fires in that cycle.
  - Next state is EMPTY; in_data presented that cycle is dropped.
  - An out_fire in the same cycle still counts as delivered downstream; the stage still empties.
  - If CLEAR_ON_FLUSH=1, main and skid are set to 0.
- Latency and throughput:
  - 1 cycle from in_fire to out_valid with that payload.
  - Sustained throughput 1 transfer/cycle when out_ready=1.
  - Order is strictly FIFO; no payload is duplicated or lost except by flush.
- Stability rules:
  - While out_valid=1 and out_ready=0, out_data and out_valid hold until out_fire or flush.
  - in_ready changes only on clock edges.
- Reset asserted mid-transfer: all entries discarded immediately; in_ready=1 after deassertion.
- Payload bits are opaque; no width conversion, no sign handling.

Optional Feature:
- Macro: PIPE_STAGE_PERF_EN.
- Defined:
  - stall_count increments (wraps at 2^CNT_W) each cycle with out_valid=1 & out_ready=0.
  - bubble_count increments (wraps) each cycle with out_valid=0 & out_ready=1.
  - Neither counter increments during rst; flush does not clear them.
- Not defined: both ports and counter logic absent; all other behaviour identical.

Test Plan:
- Reset release, then in_valid=1, in_data=0x00400000_00000013, out_ready=1 -> next cycle out_valid=1, out_data=0x00400000_00000013; in_ready stays 1.
- Stream 8 payloads (0..7) back-to-back with out_ready=1 -> out_data 0..7 on 8 consecutive cycles; no gap after the first.
- out_ready=0 while sending A then B -> in_ready=0 after B accepted and state FULL. Raise out_ready -> A then B delivered in consecutive cycles; in_ready returns to 1 the cycle after A leaves.
- FULL state plus flush=1 with in_valid=1, in_data=C -> next cycle out_valid=0, in_ready=1; C never appears; out_data=0 with CLEAR_ON_FLUSH=1.
- rst driven low asynchronously mid-cycle while in FULL -> out_valid=0 and out_data=0 before the next clock edge.
- With PIPE_STAGE_PERF_EN: 5 cycles of out_valid=1, out_ready=0 then 3 cycles empty with out_ready=1 -> stall_count=5, bubble_count=3.
